// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, writeback select and 8x16 register file.
// Decode read ports are combinational with a same-cycle bypass from W.
module writeback_stage #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWriteM,
    input  logic              MemtoRegM,
    input  logic [ADDR_W-1:0] WriteRegM,
    input  logic [DATA_W-1:0] MemReadDataM,
    input  logic [DATA_W-1:0] alu_resultM,
    input  logic              StallW,
    input  logic              FlushW,
    input  logic [ADDR_W-1:0] ReadReg1D,
    input  logic [ADDR_W-1:0] ReadReg2D,
    output logic [DATA_W-1:0] ReadData1D,
    output logic [DATA_W-1:0] ReadData2D,
    output logic [DATA_W-1:0] ResultW,
    output logic [ADDR_W-1:0] WriteRegW,
    output logic              RegWriteW,
    output logic [15:0]       RetireCountW
);

    logic              memtoRegW;
    logic [DATA_W-1:0] readDataW;
    logic [DATA_W-1:0] aluResultW;
    logic [DATA_W-1:0] regs [NREGS];
    logic              commitW;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWriteW  <= 1'b0;
            memtoRegW  <= 1'b0;
            WriteRegW  <= '0;
            readDataW  <= '0;
            aluResultW <= '0;
        end else if (FlushW) begin
            RegWriteW  <= 1'b0;
            memtoRegW  <= 1'b0;
            WriteRegW  <= '0;
            readDataW  <= '0;
            aluResultW <= '0;
        end else if (!StallW) begin
            RegWriteW  <= RegWriteM;
            memtoRegW  <= MemtoRegM;
            WriteRegW  <= WriteRegM;
            readDataW  <= MemReadDataM;
            aluResultW <= alu_resultM;
        end
    end

    assign ResultW = memtoRegW ? readDataW : aluResultW;

    // A stalled instruction commits once, on the first edge with StallW low
    assign commitW = RegWriteW && !StallW && (WriteRegW != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            RetireCountW <= '0;
        end else if (commitW) begin
            regs[WriteRegW] <= ResultW;
            RetireCountW    <= RetireCountW + 16'd1;
        end
    end

    always_comb begin
        ReadData1D = regs[ReadReg1D];
        if (ReadReg1D == '0) begin
            ReadData1D = '0;
        end else if (RegWriteW && (WriteRegW == ReadReg1D)) begin
            ReadData1D = ResultW;
        end
    end

    always_comb begin
        ReadData2D = regs[ReadReg2D];
        if (ReadReg2D == '0) begin
            ReadData2D = '0;
        end else if (RegWriteW && (WriteRegW == ReadReg2D)) begin
            ReadData2D = ResultW;
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: per-cycle expectations from a
// pending-write/register-array model, popped and checked by a monitor.
module tb_writeback_stage;

    logic        clk;
    logic        reset;
    logic        RegWriteM;
    logic        MemtoRegM;
    logic [2:0]  WriteRegM;
    logic [15:0] MemReadDataM;
    logic [15:0] alu_resultM;
    logic        StallW;
    logic        FlushW;
    logic [2:0]  ReadReg1D;
    logic [2:0]  ReadReg2D;
    logic [15:0] ReadData1D;
    logic [15:0] ReadData2D;
    logic [15:0] ResultW;
    logic [2:0]  WriteRegW;
    logic        RegWriteW;
    logic [15:0] RetireCountW;

    writeback_stage dut (
        .clk          (clk),
        .reset        (reset),
        .RegWriteM    (RegWriteM),
        .MemtoRegM    (MemtoRegM),
        .WriteRegM    (WriteRegM),
        .MemReadDataM (MemReadDataM),
        .alu_resultM  (alu_resultM),
        .StallW       (StallW),
        .FlushW       (FlushW),
        .ReadReg1D    (ReadReg1D),
        .ReadReg2D    (ReadReg2D),
        .ReadData1D   (ReadData1D),
        .ReadData2D   (ReadData2D),
        .ResultW      (ResultW),
        .WriteRegW    (WriteRegW),
        .RegWriteW    (RegWriteW),
        .RetireCountW (RetireCountW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit        v;
        bit [2:0]  d;
        bit [15:0] val;
    } pend_t;

    typedef struct {
        bit [15:0] res;
        bit [2:0]  wr;
        bit        rw;
        bit [15:0] cnt;
        bit [15:0] rd1;
        bit [15:0] rd2;
    } exp_t;

    pend_t     w;
    bit [15:0] rf [8];
    bit [15:0] cnt;
    exp_t      q [$];

    function automatic void chk(string nm, logic [15:0] act, logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endfunction

    function automatic void modelReset();
        w.v = 1'b0;
        w.d = 3'd0;
        w.val = 16'd0;
        for (int i = 0; i < 8; i++) rf[i] = 16'd0;
        cnt = 16'd0;
    endfunction

    function automatic void modelEdge();
        if (reset) return;
        if (w.v && !StallW && w.d != 3'd0) begin
            rf[w.d] = w.val;
            cnt = cnt + 16'd1;
        end
        if (FlushW) begin
            w.v = 1'b0;
            w.d = 3'd0;
            w.val = 16'd0;
        end else if (!StallW) begin
            w.v = RegWriteM;
            w.d = WriteRegM;
            w.val = MemtoRegM ? MemReadDataM : alu_resultM;
        end
    endfunction

    function automatic bit [15:0] rd(bit [2:0] a);
        if (a == 3'd0) return 16'd0;
        if (w.v && w.d == a) return w.val;
        return rf[a];
    endfunction

    function automatic void pushExp();
        exp_t e;
        e.res = w.val;
        e.wr  = w.d;
        e.rw  = w.v;
        e.cnt = cnt;
        e.rd1 = rd(ReadReg1D);
        e.rd2 = rd(ReadReg2D);
        q.push_back(e);
    endfunction

    task automatic step(input bit rs, input bit rw, input bit mtr,
                        input bit [2:0] wr, input bit [15:0] ld,
                        input bit [15:0] alu, input bit st, input bit fl,
                        input bit [2:0] a1, input bit [2:0] a2);
        @(posedge clk);
        modelEdge();
        #1;
        reset        = rs;
        RegWriteM    = rw;
        MemtoRegM    = mtr;
        WriteRegM    = wr;
        MemReadDataM = ld;
        alu_resultM  = alu;
        StallW       = st;
        FlushW       = fl;
        ReadReg1D    = a1;
        ReadReg2D    = a2;
        if (rs) modelReset();
        pushExp();
    endtask

    task automatic bubble(input bit st, input bit fl,
                          input bit [2:0] a1, input bit [2:0] a2);
        step(1'b0, 1'b0, 1'b0, 3'd0, 16'd0, 16'd0, st, fl, a1, a2);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("ResultW", ResultW, e.res);
                chk("WriteRegW", {13'd0, WriteRegW}, {13'd0, e.wr});
                chk("RegWriteW", {15'd0, RegWriteW}, {15'd0, e.rw});
                chk("RetireCountW", RetireCountW, e.cnt);
                chk("ReadData1D", ReadData1D, e.rd1);
                chk("ReadData2D", ReadData2D, e.rd2);
            end
        end
    end

    initial begin : stim
        reset = 1'b1;
        RegWriteM = 1'b0;
        MemtoRegM = 1'b0;
        WriteRegM = 3'd0;
        MemReadDataM = 16'd0;
        alu_resultM = 16'd0;
        StallW = 1'b0;
        FlushW = 1'b0;
        ReadReg1D = 3'd0;
        ReadReg2D = 3'd0;
        modelReset();

        for (int a = 0; a < 8; a++)
            step(1'b1, 1'b0, 1'b0, 3'd0, 16'd0, 16'd0, 1'b0, 1'b0,
                 3'(a), 3'(7 - a));
        for (int a = 0; a < 8; a++) begin
            bubble(1'b0, 1'b0, 3'(a), 3'(7 - a));
            #2;
            chk("rst_rd1", ReadData1D, 16'd0);
            chk("rst_rd2", ReadData2D, 16'd0);
        end
        chk("rst_cnt", RetireCountW, 16'd0);
        chk("rst_rw", {15'd0, RegWriteW}, 16'd0);

        step(1'b0, 1'b1, 1'b0, 3'd3, 16'h5555, 16'h1234, 1'b0, 1'b0, 3'd0, 3'd0);
        bubble(1'b0, 1'b0, 3'd3, 3'd0);
        #2;
        chk("alu_res", ResultW, 16'h1234);
        chk("alu_byp", ReadData1D, 16'h1234);
        bubble(1'b0, 1'b0, 3'd3, 3'd0);
        #2;
        chk("alu_rf", ReadData1D, 16'h1234);
        chk("alu_cnt", RetireCountW, 16'd1);

        step(1'b0, 1'b1, 1'b1, 3'd5, 16'hBEEF, 16'h0040, 1'b0, 1'b0, 3'd0, 3'd0);
        bubble(1'b0, 1'b0, 3'd0, 3'd0);
        #2;
        chk("ld_res", ResultW, 16'hBEEF);
        bubble(1'b0, 1'b0, 3'd0, 3'd5);
        #2;
        chk("ld_rf", ReadData2D, 16'hBEEF);
        chk("ld_cnt", RetireCountW, 16'd2);

        step(1'b0, 1'b1, 1'b0, 3'd0, 16'd0, 16'hFFFF, 1'b0, 1'b0, 3'd0, 3'd0);
        bubble(1'b0, 1'b0, 3'd0, 3'd0);
        #2;
        chk("r0_rd", ReadData2D, 16'd0);
        bubble(1'b0, 1'b0, 3'd0, 3'd0);
        #2;
        chk("r0_cnt", RetireCountW, 16'd2);

        step(1'b0, 1'b1, 1'b0, 3'd2, 16'd0, 16'h00AA, 1'b0, 1'b0, 3'd0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            bubble(1'b1, 1'b0, 3'd2, 3'd0);
            #2;
            chk("stl_byp", ReadData1D, 16'h00AA);
            chk("stl_cnt", RetireCountW, 16'd2);
        end
        bubble(1'b0, 1'b0, 3'd2, 3'd0);
        #2;
        chk("stl_hold", RetireCountW, 16'd2);
        bubble(1'b0, 1'b0, 3'd2, 3'd0);
        #2;
        chk("stl_rf", ReadData1D, 16'h00AA);
        chk("stl_cnt1", RetireCountW, 16'd3);

        step(1'b0, 1'b1, 1'b0, 3'd2, 16'd0, 16'h0BAD, 1'b0, 1'b0, 3'd0, 3'd0);
        bubble(1'b1, 1'b1, 3'd2, 3'd0);
        bubble(1'b0, 1'b0, 3'd2, 3'd0);
        #2;
        chk("fl_rw", {15'd0, RegWriteW}, 16'd0);
        chk("fl_rf", ReadData1D, 16'h00AA);
        bubble(1'b0, 1'b0, 3'd2, 3'd0);
        #2;
        chk("fl_cnt", RetireCountW, 16'd3);

        step(1'b0, 1'b1, 1'b0, 3'd4, 16'd0, 16'h4444, 1'b0, 1'b0, 3'd0, 3'd0);
        bubble(1'b1, 1'b0, 3'd4, 3'd0);
        step(1'b1, 1'b0, 1'b0, 3'd0, 16'd0, 16'd0, 1'b1, 1'b0, 3'd4, 3'd0);
        bubble(1'b0, 1'b0, 3'd4, 3'd0);
        bubble(1'b0, 1'b0, 3'd4, 3'd0);
        #2;
        chk("rststl_rf", ReadData1D, 16'd0);
        chk("rststl_cnt", RetireCountW, 16'd0);

        for (int i = 0; i < 3000; i++)
            step($urandom_range(299, 0) == 0, 1'($urandom), 1'($urandom),
                 3'($urandom), 16'($urandom), 16'($urandom),
                 $urandom_range(4, 0) == 0, $urandom_range(9, 0) == 0,
                 3'($urandom), 3'($urandom));
        bubble(1'b0, 1'b0, 3'd0, 3'd0);

        do
            step(1'b0, 1'b1, 1'($urandom), 3'($urandom_range(7, 1)),
                 16'($urandom), 16'($urandom), 1'b0, 1'b0,
                 3'($urandom), 3'($urandom));
        while (cnt != 16'hFFFF);
        #2;
        chk("wrap_pre", RetireCountW, 16'hFFFF);
        bubble(1'b0, 1'b0, 3'd0, 3'd0);
        #2;
        chk("wrap", RetireCountW, 16'h0000);

        bubble(1'b0, 1'b0, 3'd1, 3'd2);
        bubble(1'b0, 1'b0, 3'd6, 3'd7);
        @(negedge clk);
        #1;
        chk("sb_empty", 16'(q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
